// File: rtl/power_eval_pkg.sv
`default_nettype none
// ============================================================================
// Module      : power_eval_pkg
// Description : Shared constants and helpers for the power_slice_eval block.
//               Holds the default lane/counter widths and the rule used to
//               size the saturating toggle-counter adder.
// Revision    : 1.0 - initial release
// ============================================================================
package power_eval_pkg;

  localparam int c_def_width = 8;
  localparam int c_def_cnt_w = 16;

  // The toggle adder is one bit wider than the wider of its two operands.
  // The extra bit is the overflow indication used for saturation.
  function automatic int sat_sum_w(input int cnt_w, input int pc_w);
    return ((cnt_w > pc_w) ? cnt_w : pc_w) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/power_popcount.sv
`default_nettype none
// ============================================================================
// Module      : power_popcount
// Description : Purely combinational population count of a WIDTH-bit vector.
// Ports       : i_vec   - input vector, WIDTH bits
//               o_count - number of set bits in i_vec, $clog2(WIDTH+1) bits
// Revision    : 1.0 - initial release
// ============================================================================
module power_popcount #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]           i_vec,
  output logic [$clog2(WIDTH+1)-1:0] o_count
);

  localparam int c_pc_w = $clog2(WIDTH + 1);

  logic [c_pc_w-1:0] w_count;

  always_comb begin
    w_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_count = w_count + c_pc_w'(i_vec[i]);
    end
  end

  assign o_count = w_count;

endmodule
`default_nettype wire

// File: rtl/power_slice_eval.sv
`default_nettype none
// ============================================================================
// Module      : power_slice_eval
// Description : Two-stage valid/ready pipeline evaluating, per bit lane,
//               y = (a&c) ^ (b & (a ^ (c&d))). Each output handshake adds the
//               Hamming distance between the delivered y and the previously
//               delivered y into a saturating toggle counter.
// Ports       : clk, rst            - clock, async active-high reset
//               in_valid/in_ready   - input handshake
//               a, b, c, d          - per-lane operands (WIDTH)
//               out_valid/out_ready - output handshake
//               y                   - per-lane result (WIDTH)
//               clr_cnt             - synchronous clear of tog_cnt/tog_sat
//               tog_cnt             - accumulated output toggles (CNT_W)
//               tog_sat             - sticky counter-saturated flag
// Revision    : 1.0 - initial release
// ============================================================================
module power_slice_eval
  import power_eval_pkg::*;
#(
  parameter int WIDTH = c_def_width,
  parameter int CNT_W = c_def_cnt_w
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] tog_cnt,
  output logic             tog_sat
);

  localparam int c_pc_w  = $clog2(WIDTH + 1);
  localparam int c_sum_w = sat_sum_w(CNT_W, c_pc_w);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  // Pipeline state
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_q;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_y_prev;

  // Toggle accounting state
  logic [CNT_W-1:0] r_tog_cnt;
  logic             r_tog_sat;

  // Flow control
  logic w_hs;
  logic w_s2_load;
  logic w_s1_xfer;
  logic w_s1_load;

  // Toggle arithmetic
  logic [c_pc_w-1:0]  w_pc;
  logic [c_sum_w-1:0] w_base;
  logic [c_sum_w-1:0] w_sum;
  logic               w_ovf;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_sat_next;

  assign w_hs      = r_s2_valid & out_ready;
  assign w_s2_load = ~r_s2_valid | w_hs;
  assign w_s1_xfer = r_s1_valid & w_s2_load;
  assign w_s1_load = ~r_s1_valid | w_s1_xfer;

  // ---------------------------------------------------------------------------
  // Stage 1: partial products
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_p        <= '0;
      r_q        <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_p <= a & c;
        r_q <= b & (a ^ (c & d));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: result register, held while stalled
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_y        <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_y <= r_p ^ r_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Toggle counter
  // ---------------------------------------------------------------------------
  power_popcount #(
    .WIDTH (WIDTH)
  ) u_popcount (
    .i_vec   (r_y ^ r_y_prev),
    .o_count (w_pc)
  );

  // A clear coincident with a handshake restarts the count from this
  // handshake's popcount, so the base is forced to zero rather than ignoring
  // the handshake.
  always_comb begin
    w_base     = clr_cnt ? '0 : {{(c_sum_w - CNT_W){1'b0}}, r_tog_cnt};
    w_sum      = w_base + {{(c_sum_w - c_pc_w){1'b0}}, w_pc};
    w_ovf      = |w_sum[c_sum_w-1:CNT_W];
    w_cnt_next = w_ovf ? c_cnt_max : w_sum[CNT_W-1:0];
    w_sat_next = (clr_cnt ? 1'b0 : r_tog_sat) | w_ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_prev  <= '0;
      r_tog_cnt <= '0;
      r_tog_sat <= 1'b0;
    end else if (w_hs) begin
      r_y_prev  <= r_y;
      r_tog_cnt <= w_cnt_next;
      r_tog_sat <= w_sat_next;
    end else if (clr_cnt) begin
      r_tog_cnt <= '0;
      r_tog_sat <= 1'b0;
    end
  end

  assign in_ready  = w_s1_load;
  assign out_valid = r_s2_valid;
  assign y         = r_y;
  assign tog_cnt   = r_tog_cnt;
  assign tog_sat   = r_tog_sat;

endmodule
`default_nettype wire

// File: tb/tb_power_slice_eval.sv
`default_nettype none
// ============================================================================
// Module      : tb_power_slice_eval
// Description : Directed self-checking bench for power_slice_eval. A WIDTH=4,
//               CNT_W=16 instance covers datapath, flow control, clear and
//               reset; a WIDTH=4, CNT_W=3 instance covers saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_power_slice_eval;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // Main instance
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = '0, b = '0, c = '0, d = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] y;
  logic       clr_cnt = 1'b0;
  logic [15:0] tog_cnt;
  logic       tog_sat;

  // Narrow-counter instance
  logic       in_valid3 = 1'b0;
  logic       in_ready3;
  logic [3:0] a3 = '0, c3 = '0;
  logic [3:0] zero4 = '0;
  logic       out_valid3;
  logic       out_ready3 = 1'b1;
  logic [3:0] y3;
  logic       clr3 = 1'b0;
  logic [2:0] tog_cnt3;
  logic       tog_sat3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  power_slice_eval #(.WIDTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .clr_cnt(clr_cnt), .tog_cnt(tog_cnt), .tog_sat(tog_sat)
  );

  power_slice_eval #(.WIDTH(4), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .a(a3), .b(zero4), .c(c3), .d(zero4), .out_valid(out_valid3),
    .out_ready(out_ready3), .y(y3), .clr_cnt(clr3), .tog_cnt(tog_cnt3),
    .tog_sat(tog_sat3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int         acc;
  int         n_got;
  logic [3:0] vec;
  logic [3:0] got [0:3];

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y",         32'(y),         32'd0);
    check("rst_tog_cnt",   32'(tog_cnt),   32'd0);
    check("rst_tog_sat",   32'(tog_sat),   32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // ---------------- streaming, 2-cycle latency ----------------
    in_valid = 1'b1; out_ready = 1'b1;
    a = 4'b1111; b = 4'b0000; c = 4'b1010; d = 4'b0000;
    tick();                                       // edge E: accept #1
    a = 4'b0101; b = 4'b0000; c = 4'b0101; d = 4'b0000;
    check("lat_out_valid_E", 32'(out_valid), 32'd0);
    tick();                                       // E+1: y #1 valid, accept #2
    a = 4'b0000; b = 4'b1111; c = 4'b1111; d = 4'b1111;
    check("v1_out_valid", 32'(out_valid), 32'd1);
    check("v1_y",         32'(y),         32'hA);
    tick();                                       // hs y=A, accept #3
    in_valid = 1'b0;
    check("v1_tog", 32'(tog_cnt), 32'd2);
    check("v2_y",   32'(y),       32'h5);
    tick();                                       // hs y=5
    check("v2_tog", 32'(tog_cnt), 32'd6);
    check("v3_y",   32'(y),       32'hF);
    tick();                                       // hs y=F
    check("v3_tog",       32'(tog_cnt),   32'd8);
    check("drain_valid",  32'(out_valid), 32'd0);

    // ---------------- per-lane function ----------------
    in_valid = 1'b1;
    a = 4'b0110; b = 4'b0111; c = 4'b0011; d = 4'b0011;
    tick();
    in_valid = 1'b0;
    tick();
    check("lane_y", 32'(y), 32'h7);
    tick();
    check("lane_tog", 32'(tog_cnt), 32'd9);

    // ---------------- stall with both stages full ----------------
    vec = 4'd1; acc = 0;
    b = 4'b0000; c = 4'b1111; d = 4'b0000;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = vec;
      #1;
      if (in_ready) begin
        acc++;
        vec = vec + 4'd1;
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("stall_accepts",  32'(acc),       32'd2);
    check("stall_in_ready", 32'(in_ready),  32'd0);
    check("stall_valid",    32'(out_valid), 32'd1);
    check("stall_y",        32'(y),         32'h1);
    out_ready = 1'b1;
    n_got = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid && n_got < 4) begin
        got[n_got] = y;
        n_got++;
      end
      tick();
    end
    check("drain_count", 32'(n_got),  32'd2);
    check("drain_first", 32'(got[0]), 32'h1);
    check("drain_second",32'(got[1]), 32'h2);
    check("drain_tog",   32'(tog_cnt), 32'd13);

    // ---------------- clr_cnt alone; y_prev kept ----------------
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_tog", 32'(tog_cnt), 32'd0);
    check("clr_sat", 32'(tog_sat), 32'd0);
    in_valid = 1'b1; a = 4'b0011; c = 4'b1111;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("yprev_kept_tog", 32'(tog_cnt), 32'd1);

    // ---------------- saturation on 3-bit counter ----------------
    c3 = 4'b1111; in_valid3 = 1'b1; a3 = 4'b1111;
    tick();
    a3 = 4'b0000;
    tick();
    a3 = 4'b1111;
    tick();
    in_valid3 = 1'b0;
    check("sat_tog_4", 32'(tog_cnt3), 32'd4);
    check("sat_flag_0",32'(tog_sat3), 32'd0);
    tick();
    check("sat_tog_7", 32'(tog_cnt3), 32'd7);
    check("sat_flag_1",32'(tog_sat3), 32'd1);
    clr3 = 1'b1;
    tick();
    clr3 = 1'b0;
    check("clr_hs_tog", 32'(tog_cnt3), 32'd4);
    check("clr_hs_sat", 32'(tog_sat3), 32'd0);

    // ---------------- asynchronous reset mid-stream ----------------
    in_valid = 1'b1; a = 4'b1100; c = 4'b1111;
    tick();
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_y",     32'(y),         32'd0);
    check("arst_tog",   32'(tog_cnt),   32'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = 4'b0011; c = 4'b1111;
    tick();
    in_valid = 1'b0;
    tick();
    check("post_rst_y", 32'(y), 32'h3);
    tick();
    check("post_rst_tog", 32'(tog_cnt), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/power_slice_eval.md
POWER_SLICE_EVAL -- requirements
Module: power_slice_eval

Interface
REQ-001 Parameter WIDTH, default 8: number of independent bit lanes evaluated per transaction.
REQ-002 Parameter CNT_W, default 16: width of output toggle counter.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port in_valid, input, 1: upstream transaction valid.
REQ-006 Port in_ready, output, 1: block can accept a transaction this cycle.
REQ-007 Ports a, b, c, d, input, WIDTH each: per-lane operands.
REQ-008 Port out_valid, output, 1: y holds a valid result.
REQ-009 Port out_ready, input, 1: downstream accepts y this cycle.
REQ-010 Port y, output, WIDTH: per-lane result.
REQ-011 Port clr_cnt, input, 1: synchronous clear of tog_cnt and tog_sat.
REQ-012 Port tog_cnt, output, CNT_W: accumulated output bit toggles.
REQ-013 Port tog_sat, output, 1: sticky flag, tog_cnt has saturated.

Function
REQ-014 Per lane i, y[i] SHALL equal (a[i]&c[i]) ^ (b[i] & (a[i] ^ (c[i]&d[i]))).
REQ-015 Stage 1 SHALL register p = a&c and q = b&(a^(c&d)); stage 2 SHALL register y = p^q.
REQ-016 Input accepted (in_valid & in_ready) at edge E SHALL produce out_valid=1 with its y after edge E+1 when unstalled (2-cycle latency).
REQ-017 Output handshake SHALL occur when out_valid & out_ready; y and out_valid SHALL hold stable while out_valid & !out_ready.
REQ-018 Stage 2 SHALL load when empty or handshaking; stage 1 SHALL load when empty or transferring to stage 2.
REQ-019 in_ready SHALL be combinationally !s1_valid | stage-1 transfer; full throughput one transaction per cycle with out_ready held 1.
REQ-020 With both stages full and out_ready=0, in_ready SHALL be 0 and no data lost or duplicated.
REQ-021 Simultaneous input accept and output handshake SHALL both take effect in the same cycle.
REQ-022 Block SHALL keep y_prev (WIDTH), updated to y on each output handshake.
REQ-023 On each output handshake, tog_cnt SHALL add popcount(y ^ y_prev), saturating at 2^CNT_W-1.
REQ-024 tog_sat SHALL set when an addition would exceed 2^CNT_W-1 and stay set until clr_cnt or rst.
REQ-025 clr_cnt alone SHALL zero tog_cnt and tog_sat; y_prev unaffected.
REQ-026 clr_cnt coincident with handshake: tog_cnt SHALL become that handshake's popcount, tog_sat 0.
REQ-027 Pipeline flow SHALL be independent of clr_cnt.

Reset
REQ-028 rst SHALL force, asynchronously: stage valids 0, out_valid 0, y 0, y_prev 0, tog_cnt 0, tog_sat 0.
REQ-029 rst mid-transaction SHALL discard in-flight data; first post-reset result counts toggles against y_prev=0.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-031 Package power_eval_pkg SHALL hold default WIDTH/CNT_W constants and the saturating-add width rule.
REQ-032 One sub-module power_popcount (parameter WIDTH, output $clog2(WIDTH+1) bits) SHALL compute popcount of y ^ y_prev.
REQ-033 Implementation SHALL be 120-400 lines RTL, no latches, no gated clocks.

Verification (WIDTH=4, CNT_W=16 unless noted)
REQ-034 a=4'b1111,b=0,c=4'b1010,d=0 accepted at edge E, out_ready=1 -> out_valid after E+1, y=4'b1010, tog_cnt=2.
REQ-035 Next a=4'b0101,b=0,c=4'b0101,d=0 -> y=4'b0101, tog_cnt=6; then a=0,b=4'b1111,c=4'b1111,d=4'b1111 -> y=4'b1111, tog_cnt=8.
REQ-036 Lane check a=0,b=1,c=1,d=1 -> 1; a=1,b=1,c=1,d=1 -> 1; a=1,b=1,c=0,d=0 -> 1; all-zero -> 0.
REQ-037 out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 accepted, in_ready=0 thereafter, y stable; release -> results in order, none lost.
REQ-038 CNT_W=3, alternating y=4'b1111/4'b0000 -> tog_cnt 4 then 7, tog_sat=1; clr_cnt coincident with next handshake -> tog_cnt=4, tog_sat=0.
REQ-039 rst asserted mid-stream between edges -> out_valid, y, tog_cnt immediately 0; first post-reset y=4'b0011 -> tog_cnt=2.
